imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: immediate output width; legal values are 32 and 64.
REQ-002 SHALL have parameter AUTO_DECODE, default 1: 1 derives the immediate type from the opcode; 0 takes it from in_imm_src.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: in_instr and in_imm_src are valid.
REQ-006 SHALL have port in_ready, output, 1: stage accepts input this cycle.
REQ-007 SHALL have port in_instr, input, 32: raw RV instruction word.
REQ-008 SHALL have port in_imm_src, input, 3: type select with 000 I, 001 S, 010 B, 011 U, 100 J; all others illegal; ignored when AUTO_DECODE=1.
REQ-009 SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-010 SHALL have port out_valid, output, 1: output entry is valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the output entry.
REQ-012 SHALL have port out_imm, output, XLEN: sign-extended immediate.
REQ-013 SHALL have port out_type, output, 3: resolved type code, same encoding as in_imm_src.
REQ-014 SHALL have port out_illegal, output, 1: type unresolvable; out_imm is 0 when set.

Function
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-016 Immediate formats SHALL be:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- All formats are sign-extended from instr[31] to XLEN.
REQ-017 With AUTO_DECODE=1, opcode instr[6:0] SHALL map as follows; any other opcode is illegal.
- 0010011, 0000011, 1100111 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
REQ-018 Illegal entries SHALL still be transferred in order with out_illegal=1 and out_imm=0.
REQ-019 The stage SHALL be a 2-entry skid buffer: an output register plus a skid register.
- States: EMPTY, ONE, TWO.
- State encoding in the package.
REQ-020 Latency SHALL be 1 cycle: an entry accepted in EMPTY appears on out_* in the next cycle.
REQ-021 The stage SHALL sustain 1 transfer per cycle whenever out_ready is held high.
REQ-022 in_ready SHALL be a decode of the state register only: 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready.
REQ-023 State transitions (in = input transfer, out = output transfer):
- EMPTY: in -> ONE.
- ONE: in and not out -> TWO; out and not in -> EMPTY; both -> ONE, with the new entry loaded into the output register.
- TWO: out -> ONE, with the skid entry moved into the output register; input is never accepted in TWO.
REQ-024 Entries SHALL leave in exact acceptance order.
REQ-025 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL move the stage to EMPTY on the next edge and discard held entries.
- An input offered in the flush cycle is dropped.
- An output transfer in the flush cycle still counts as consumed.
REQ-027 Data registers SHALL load only on accepted transfers; out_imm/out_type/out_illegal SHALL be don't-care while out_valid=0.

Reset
REQ-028 While rst_n=0 the stage SHALL be in EMPTY with out_valid=0, in_ready=1, out_imm=0, out_type=000, out_illegal=0.
REQ-029 Assertion of rst_n mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-030 The first transfer SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package imm_pkg SHALL hold:
- the type-code enum (I, S, B, U, J);
- the opcode constants;
- the skid state enum.
REQ-032 The combinational format/type decode SHALL live in sub-module imm_ext_core (parameter XLEN), instantiated once, on the input side ahead of the registers.

Verification
REQ-033 Format decode, AUTO_DECODE=1, XLEN=32, out_ready=1:
- 0xFFF00093 -> I, out_imm 0xFFFFFFFF.
- 0x0020A423 -> S, 0x00000008.
- 0xFE000EE3 -> B, 0xFFFFFFFC.
- 0x123452B7 -> U, 0x12345000.
- 0x001000EF -> J, 0x00000800.
- Each out_valid appears 1 cycle after acceptance.
REQ-034 Illegal and wide cases:
- 0x0000007F -> out_illegal=1, out_imm=0.
- XLEN=64 with 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
- AUTO_DECODE=0 with in_imm_src=111 -> illegal.
REQ-035 Backpressure: out_ready=0 while offering A, B, C back-to-back.
- A and B are accepted; in_ready=0 on the third cycle.
- Raising out_ready yields A, B, C in order with no duplicates.
- out_* stays stable while stalled.
REQ-036 Throughput: 16 consecutive instructions with out_ready=1 -> 16 outputs in 16 consecutive cycles, first at cycle 1.
REQ-037 Flush in TWO, with an input offered in the same cycle:
- Next cycle: out_valid=0, in_ready=1.
- The offered input never appears at the output.
REQ-038 Reset mid-operation: rst_n pulsed low asynchronously between edges while in TWO -> out_valid=0 immediately; after release, a new instruction is accepted and output normally.

Source files
------------

// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared types and constants for the immediate decode stage:
//               immediate type codes, RV opcode constants, skid FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Immediate type code, also the encoding of in_imm_src / out_type.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_type_e;

    // Opcodes (instr[6:0]) that carry an immediate.
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate type resolution, field extraction and
//               sign extension of an RV instruction word to XLEN bits.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_imm_src,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_type,
    output logic            o_illegal
);

    logic [2:0]  w_type;
    logic        w_illegal;
    logic [31:0] w_imm32;

    // Resolve the type either from the opcode or from the explicit select.
    always_comb begin
        w_type    = IMM_I;
        w_illegal = 1'b0;
        if (AUTO_DECODE) begin
            case (i_instr[6:0])
                c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR: w_type = IMM_I;
                c_OPC_STORE:                          w_type = IMM_S;
                c_OPC_BRANCH:                         w_type = IMM_B;
                c_OPC_LUI, c_OPC_AUIPC:               w_type = IMM_U;
                c_OPC_JAL:                            w_type = IMM_J;
                default:                              w_illegal = 1'b1;
            endcase
        end else begin
            w_type = i_imm_src;
            if (i_imm_src > IMM_J) begin
                w_illegal = 1'b1;
            end
        end
    end

    // Assemble the 32-bit immediate; every format carries instr[31] in bit 31,
    // so the wider result only needs bit 31 replicated.
    always_comb begin
        w_imm32 = 32'd0;
        if (!w_illegal) begin
            case (w_type)
                IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                    i_instr[30:25], i_instr[11:8], 1'b0};
                IMM_U:   w_imm32 = {i_instr[31:12], 12'd0};
                IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                    i_instr[20], i_instr[30:21], 1'b0};
                default: w_imm32 = 32'd0;
            endcase
        end
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_narrow
            assign o_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

    assign o_type    = w_type;
    assign o_illegal = w_illegal;

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Immediate decode pipeline stage with a two-entry skid buffer
//               (output register + skid register), one-cycle latency and
//               full throughput; in_ready depends on state only.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_src,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    skid_state_e     r_state;
    skid_state_e     w_state_nxt;

    logic [XLEN-1:0] w_dec_imm;
    logic [2:0]      w_dec_type;
    logic            w_dec_illegal;

    logic [XLEN-1:0] r_out_imm;
    logic [2:0]      r_out_type;
    logic            r_out_illegal;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_type;
    logic            r_skid_illegal;

    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_load_out_dec;
    logic            w_load_out_skid;
    logic            w_load_skid;

    // Decode sits ahead of the registers so the output is a clean flop.
    imm_ext_core #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_ext_core (
        .i_instr   (in_instr),
        .i_imm_src (in_imm_src),
        .o_imm     (w_dec_imm),
        .o_type    (w_dec_type),
        .o_illegal (w_dec_illegal)
    );

    assign in_ready   = (r_state != ST_TWO);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and register load enables; flush discards everything,
    // including any input offered in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_dec  = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt    = ST_ONE;
                        w_load_out_dec = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_out_dec = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_nxt = ST_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt     = ST_ONE;
                        w_load_out_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Output register: loads from the decoder or from the skid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_imm     <= '0;
            r_out_type    <= 3'b000;
            r_out_illegal <= 1'b0;
        end else if (w_load_out_dec) begin
            r_out_imm     <= w_dec_imm;
            r_out_type    <= w_dec_type;
            r_out_illegal <= w_dec_illegal;
        end else if (w_load_out_skid) begin
            r_out_imm     <= r_skid_imm;
            r_out_type    <= r_skid_type;
            r_out_illegal <= r_skid_illegal;
        end
    end

    // Skid register: catches the entry accepted while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_imm     <= '0;
            r_skid_type    <= 3'b000;
            r_skid_illegal <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_imm     <= w_dec_imm;
            r_skid_type    <= w_dec_type;
            r_skid_illegal <= w_dec_illegal;
        end
    end

    assign out_imm     = r_out_imm;
    assign out_type    = r_out_type;
    assign out_illegal = r_out_illegal;

endmodule : imm_decode_stage
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Self-checking bench: three stage instances (32-bit auto,
//               64-bit auto, 32-bit explicit select) against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [2:0]  in_imm_src = 3'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_type;
    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_imm;
    logic [2:0]  w_out_type;
    logic        m_in_ready, m_out_valid, m_out_illegal;
    logic [31:0] m_out_imm;
    logic [2:0]  m_out_type;

    int errors = 0;
    int checks = 0;

    exp_t qa[$];
    exp_t qw[$];
    exp_t qm[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_type(a_out_type), .out_illegal(a_out_illegal));

    imm_decode_stage #(.XLEN(64), .AUTO_DECODE(1'b1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_out_imm),
        .out_type(w_out_type), .out_illegal(w_out_illegal));

    imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b0)) u_dutman (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .flush(flush),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_imm(m_out_imm),
        .out_type(m_out_type), .out_illegal(m_out_illegal));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode: field value minus 2^width when the sign bit is set.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [2:0] src,
                                        input bit auto_d, input int xlen);
        exp_t  e;
        int    t;
        int    w;
        longint f;
        longint v;
        t = -1;
        if (auto_d) begin
            case (ins[6:0])
                7'h13, 7'h03, 7'h67: t = 0;
                7'h23:               t = 1;
                7'h63:               t = 2;
                7'h37, 7'h17:        t = 3;
                7'h6F:               t = 4;
                default:             t = -1;
            endcase
        end else if (src <= 3'd4) begin
            t = int'(src);
        end
        f = 0;
        w = 32;
        case (t)
            0: begin f = longint'(ins[31:20]); w = 12; end
            1: begin f = longint'({ins[31:25], ins[11:7]}); w = 12; end
            2: begin f = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2; w = 13; end
            3: begin f = longint'(ins[31:12]) * 4096; w = 32; end
            4: begin f = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2; w = 21; end
            default: begin f = 0; w = 32; end
        endcase
        v = (ins[31] && t >= 0) ? f - (longint'(1) <<< w) : f;
        e.ill = (t < 0);
        e.typ = (t < 0) ? src : 3'(t);
        e.imm = (t < 0) ? 64'd0 : ((xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v));
        return e;
    endfunction

    // Behavioural model: a FIFO of at most two entries per instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete(); qw.delete(); qm.delete();
        end else begin
            automatic bit do_out = (qa.size() > 0) && out_ready;
            automatic bit do_in  = in_valid && (qa.size() < 2);
            if (flush) begin
                qa.delete(); qw.delete(); qm.delete();
            end else begin
                if (do_out) begin
                    void'(qa.pop_front()); void'(qw.pop_front()); void'(qm.pop_front());
                end
                if (do_in) begin
                    qa.push_back(ref_decode(in_instr, in_imm_src, 1'b1, 32));
                    qw.push_back(ref_decode(in_instr, in_imm_src, 1'b1, 64));
                    qm.push_back(ref_decode(in_instr, in_imm_src, 1'b0, 32));
                end
            end
        end
    end

    // Continuous compare on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", {61'd0, a_out_valid, w_out_valid, m_out_valid}, 64'd0);
            chk("rst_ready", {61'd0, a_in_ready, w_in_ready, m_in_ready}, 64'd7);
            chk("rst_imm", w_out_imm | {32'd0, a_out_imm} | {32'd0, m_out_imm}, 64'd0);
        end else begin
            chk("valid", {61'd0, a_out_valid, w_out_valid, m_out_valid},
                (qa.size() > 0) ? 64'd7 : 64'd0);
            chk("ready", {61'd0, a_in_ready, w_in_ready, m_in_ready},
                (qa.size() < 2) ? 64'd7 : 64'd0);
            if (qa.size() > 0) begin
                chk("a_ill", {63'd0, a_out_illegal}, {63'd0, qa[0].ill});
                chk("a_imm", {32'd0, a_out_imm}, qa[0].imm);
                if (!qa[0].ill) chk("a_type", {61'd0, a_out_type}, {61'd0, qa[0].typ});
                chk("w_ill", {63'd0, w_out_illegal}, {63'd0, qw[0].ill});
                chk("w_imm", w_out_imm, qw[0].imm);
                if (!qw[0].ill) chk("w_type", {61'd0, w_out_type}, {61'd0, qw[0].typ});
                chk("m_ill", {63'd0, m_out_illegal}, {63'd0, qm[0].ill});
                chk("m_imm", {32'd0, m_out_imm}, qm[0].imm);
                if (!qm[0].ill) chk("m_type", {61'd0, m_out_type}, {61'd0, qm[0].typ});
            end
        end
    end

    // One instruction into an empty stage, checked one cycle later.
    task automatic send1(input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] req_imm, input logic req_ill, input string name);
        @(posedge clk); #2;
        in_valid = 1'b1; in_instr = ins; in_imm_src = src; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, {63'd0, a_out_valid}, 64'd1);
        chk({name, "_imm"}, {32'd0, a_out_imm}, {32'd0, req_imm});
        chk({name, "_ill"}, {63'd0, a_out_illegal}, {63'd0, req_ill});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc [9];
        logic [31:0] r;
        opc = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        r = $urandom();
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], opc[$urandom_range(0, 8)]};
    endfunction

    initial begin
        int nvalid;
        // Reset values while rst_n is low.
        #1;
        chk("reset_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("reset_out_imm", {32'd0, a_out_imm}, 64'd0);
        chk("reset_out_type", {61'd0, a_out_type}, 64'd0);
        chk("reset_out_illegal", {63'd0, a_out_illegal}, 64'd0);

        // First transfer on the first edge after release.
        in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1;
        #11 rst_n = 1'b1;
        @(posedge clk); #2; in_valid = 1'b0;
        @(negedge clk);
        chk("first_valid", {63'd0, a_out_valid}, 64'd1);
        chk("first_imm", {32'd0, a_out_imm}, 64'hFFFF_FFFF);

        // Format decode literals.
        send1(32'hFFF00093, 3'd0, 32'hFFFF_FFFF, 1'b0, "fmt_I");
        chk("fmt_I_type", {61'd0, a_out_type}, 64'd0);
        chk("wide_I_imm", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        send1(32'h0020A423, 3'd1, 32'h0000_0008, 1'b0, "fmt_S");
        chk("fmt_S_type", {61'd0, a_out_type}, 64'd1);
        send1(32'hFE000EE3, 3'd2, 32'hFFFF_FFFC, 1'b0, "fmt_B");
        chk("fmt_B_type", {61'd0, a_out_type}, 64'd2);
        send1(32'h123452B7, 3'd3, 32'h1234_5000, 1'b0, "fmt_U");
        chk("fmt_U_type", {61'd0, a_out_type}, 64'd3);
        send1(32'h001000EF, 3'd4, 32'h0000_0800, 1'b0, "fmt_J");
        chk("fmt_J_type", {61'd0, a_out_type}, 64'd4);
        send1(32'h0000007F, 3'd0, 32'h0, 1'b1, "illegal_opc");
        send1(32'hFFF00093, 3'd7, 32'hFFFF_FFFF, 1'b0, "man_src7");
        chk("man_src7_ill", {63'd0, m_out_illegal}, 64'd1);
        chk("man_src7_imm", {32'd0, m_out_imm}, 64'd0);

        // Backpressure: A, B accepted, C held off, then drained in order.
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
        @(posedge clk); #2; in_instr = 32'h00200093;
        @(posedge clk); #2; in_instr = 32'h00300093;
        @(negedge clk);
        chk("bp_in_ready", {63'd0, a_in_ready}, 64'd0);
        chk("bp_head_A", {32'd0, a_out_imm}, 64'd1);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_stable_A", {32'd0, a_out_imm}, 64'd1);
        @(posedge clk); #2; out_ready = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_then_B", {32'd0, a_out_imm}, 64'd2);
        @(posedge clk); #2; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_then_C", {32'd0, a_out_imm}, 64'd3);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_drained", {63'd0, a_out_valid}, 64'd0);

        // Throughput: 16 back-to-back with out_ready high.
        nvalid = 0;
        for (int i = 0; i <= 16; i++) begin
            @(posedge clk); #2;
            if (i < 16) begin
                in_valid = 1'b1; in_instr = rand_instr();
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                @(negedge clk);
                if (a_out_valid && a_in_ready) nvalid++;
            end
        end
        chk("thru_count", 64'(nvalid), 64'd16);

        // Flush in TWO with an input offered in the same cycle.
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
        @(posedge clk); #2; in_instr = 32'h00600093;
        @(posedge clk); #2; flush = 1'b1; in_instr = 32'h00700093;
        @(posedge clk); #2; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'd0, a_out_valid}, 64'd0);
        chk("flush_ready", {63'd0, a_in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_ghost", {63'd0, a_out_valid}, 64'd0);
        end

        // Asynchronous reset while in TWO.
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00800093;
        @(posedge clk); #2; in_instr = 32'h00900093;
        @(posedge clk); #2; in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, a_out_valid}, 64'd0);
        chk("arst_ready", {63'd0, a_in_ready}, 64'd1);
        #3 rst_n = 1'b1;
        send1(32'h001000EF, 3'd4, 32'h0000_0800, 1'b0, "post_arst");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_instr   = rand_instr();
            in_imm_src = 3'($urandom_range(0, 7));
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imm_decode_stage
`default_nettype wire
